symbol_pack_arb: RTL and testbench
==================================

SYMBOL_PACK_ARB -- requirements
Module: symbol_pack_arb

Interface
REQ-001 Parameter NREQ, default 4, number of symbol requesters (2..16).
REQ-002 Parameter PQ_SYMBOLS, default 8, 4-bit symbols per packed output word (1..32).
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port i_en  input  1  global enable; low freezes all state.
REQ-006 Port i_req_valid  input  NREQ  per-requester symbol valid.
REQ-007 Port i_req_sym  input  NREQ*4  per-requester symbol; requester k on bits [4k+3:4k].
REQ-008 Port i_req_last  input  NREQ  marks final symbol of a requester's burst.
REQ-009 Port o_req_ready  output  NREQ  per-requester accept strobe.
REQ-010 Port o_grant  output  NREQ  one-hot current owner; all-zero when none.
REQ-011 Port o_all_symbols_4b  output  PQ_SYMBOLS*4  packed word; slot s on bits [4s+3:4s].
REQ-012 Port o_sym_count  output  $clog2(PQ_SYMBOLS+1)  valid slots in o_all_symbols_4b.
REQ-013 Port o_valid  output  1  packed word valid.
REQ-014 Port i_ready  input  1  downstream accept of packed word.

Function
REQ-015 FSM states IDLE, COLLECT, OUT; reset state IDLE.
REQ-016 IDLE: with i_en=1 and any i_req_valid bit set, select owner round-robin, searching from index ptr+1 mod NREQ upward; register o_grant, clear slot count; next state COLLECT.
REQ-017 IDLE with no valid request: o_grant stays zero, state holds.
REQ-018 COLLECT: o_req_ready = o_grant when i_en=1, else zero; ready never asserted for non-owners.
REQ-019 Symbol accepted when i_req_valid[g] and o_req_ready[g]; written to slot o_sym_count, then count increments by 1.
REQ-020 COLLECT to OUT when accepted symbol fills slot PQ_SYMBOLS-1 or carries i_req_last[g]; o_valid rises the next cycle.
REQ-021 Owner dropping valid in COLLECT stalls the FSM; no timeout, no re-arbitration.
REQ-022 OUT: o_valid=1; o_all_symbols_4b, o_sym_count, o_grant held stable until o_valid and i_ready both high.
REQ-023 Slots at or above o_sym_count read as zero.
REQ-024 On OUT handshake: ptr takes the owner index, o_grant clears, o_valid deasserts next cycle, state IDLE.
REQ-025 A burst longer than PQ_SYMBOLS splits across words; after OUT the owner re-arbitrates in IDLE against others (no grant retention).
REQ-026 i_en=0: no acceptance, no state, pointer, or count change; o_valid and data in OUT held; handshake with i_ready ignored.
REQ-027 Latency: request seen in IDLE at cycle N -> o_grant at N+1 -> first accept earliest N+1; last accept at M -> o_valid at M+1.
REQ-028 Simultaneous requests: exactly one grant per arbitration; priority order rotates so no requester waits more than NREQ-1 bursts.

Reset
REQ-029 rst synchronous active-high dominates i_en: state IDLE, ptr=NREQ-1 (requester 0 wins first), count 0.
REQ-030 During and after rst: o_valid=0, o_grant=0, o_req_ready=0, o_sym_count=0, o_all_symbols_4b=0.
REQ-031 rst mid-COLLECT or mid-OUT discards the partial or pending word; no output handshake completes.

Structure
REQ-032 Package symbol_pack_arb_pkg holds SYM_W=4 constant and the FSM state enum typedef.
REQ-033 Sub-module rr_arbiter (NREQ requests, pointer in, one-hot grant out, combinational) performs selection.

Verification
REQ-034 Single requester 2 sends 8 symbols 0x1..0x8, last on 8th -> one word 0x87654321, count 8, grant 0b0100.
REQ-035 Requesters 0,1,3 valid together after reset -> grant order 0,1,3, then 0 again when all persist.
REQ-036 Requester 1 sends 3 symbols A,B,C with last -> word 0x00000CBA, count 3.
REQ-037 i_ready low 5 cycles in OUT, then i_en low during accepted beat -> word stable, no handshake until i_en=1 and i_ready=1.
REQ-038 rst asserted after 4 symbols accepted -> next cycle all outputs zero; following burst starts at slot 0 with requester 0 priority.
REQ-039 12-symbol burst from requester 0 with PQ_SYMBOLS=8 -> two words, counts 8 then 4.

Source files
------------

// File: rtl/symbol_pack_arb_pkg.sv
// Shared constants and FSM state type for the symbol packing arbiter.
package symbol_pack_arb_pkg;
  localparam int SYM_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUT
  } state_t;
endpackage

// File: rtl/symbol_pack_arb_if.sv
// Requester-side and packed-output-side signals of symbol_pack_arb.
interface symbol_pack_arb_if
  import symbol_pack_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int PQ_SYMBOLS = 8
);
  localparam int CW = $clog2(PQ_SYMBOLS + 1);

  logic                        i_en;
  logic [NREQ-1:0]             i_req_valid;
  logic [NREQ*SYM_W-1:0]       i_req_sym;
  logic [NREQ-1:0]             i_req_last;
  logic [NREQ-1:0]             o_req_ready;
  logic [NREQ-1:0]             o_grant;
  logic [PQ_SYMBOLS*SYM_W-1:0] o_all_symbols_4b;
  logic [CW-1:0]               o_sym_count;
  logic                        o_valid;
  logic                        i_ready;

  modport slave (
    input  i_en, i_req_valid, i_req_sym, i_req_last, i_ready,
    output o_req_ready, o_grant, o_all_symbols_4b, o_sym_count, o_valid
  );

  modport master (
    output i_en, i_req_valid, i_req_sym, i_req_last, i_ready,
    input  o_req_ready, o_grant, o_all_symbols_4b, o_sym_count, o_valid
  );
endinterface

// File: rtl/symbol_pack_arb_rr_arbiter.sv
// Combinational round-robin selector: first active request above i_ptr wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);
  int unsigned w_k;
  logic        w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_k = (32'(i_ptr) + i) % NREQ;
      if (!w_found && i_req[w_k[PW-1:0]]) begin
        o_grant[w_k[PW-1:0]] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end
endmodule

// File: rtl/symbol_pack_arb.sv
// Arbitrates NREQ 4-bit symbol streams and packs one owner's burst into a word.
module symbol_pack_arb
  import symbol_pack_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int PQ_SYMBOLS = 8
) (
  input logic              clk,
  input logic              rst,
  symbol_pack_arb_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PQ_SYMBOLS + 1);
  localparam int DW = PQ_SYMBOLS * SYM_W;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_idx;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_data;
  logic            r_valid;

  logic [NREQ-1:0]  w_arb_grant;
  logic [PW-1:0]    w_arb_idx;
  logic [SYM_W-1:0] w_sym;
  logic             w_sym_last;
  logic             w_full;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req   (bus.i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_arb_grant[i]) w_arb_idx = PW'(i);
    end
  end

  assign w_sym      = bus.i_req_sym[r_idx*SYM_W +: SYM_W];
  assign w_sym_last = bus.i_req_last[r_idx];
  assign w_full     = (r_count == CW'(PQ_SYMBOLS - 1));

  // Word buffer is cleared on arbitration and handshake so unused slots read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= PW'(NREQ - 1);
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (bus.i_en) begin
      unique case (r_state)
        IDLE: begin
          if (|bus.i_req_valid) begin
            r_grant <= w_arb_grant;
            r_idx   <= w_arb_idx;
            r_count <= '0;
            r_data  <= '0;
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.i_req_valid[r_idx]) begin
            for (int unsigned s = 0; s < PQ_SYMBOLS; s++) begin
              if (r_count == CW'(s)) r_data[s*SYM_W +: SYM_W] <= w_sym;
            end
            r_count <= r_count + CW'(1);
            if (w_full || w_sym_last) begin
              r_state <= OUT;
              r_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (bus.i_ready) begin
            r_ptr   <= r_idx;
            r_grant <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready      = (r_state == COLLECT && bus.i_en) ? r_grant : '0;
  assign bus.o_grant          = r_grant;
  assign bus.o_all_symbols_4b = r_data;
  assign bus.o_sym_count      = r_count;
  assign bus.o_valid          = r_valid;
endmodule

// File: tb/tb_symbol_pack_arb.sv
// Self-checking bench for symbol_pack_arb: directed table, corner sequences, random vs model.
module tb_symbol_pack_arb;
  localparam int NREQ = 4;
  localparam int PQ   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  symbol_pack_arb_if #(.NREQ(NREQ), .PQ_SYMBOLS(PQ)) bus ();

  symbol_pack_arb #(.NREQ(NREQ), .PQ_SYMBOLS(PQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner, collected symbols, word-complete flag.
  int         m_owner;
  int         m_last;
  bit         m_pend;
  logic [3:0] m_q[$];
  bit         m_live = 1'b0;

  logic        cur_r, cur_e, cur_rd;
  logic [3:0]  cur_v, cur_l;
  logic [15:0] cur_s;

  logic [31:0] cap_data[$];
  int          cap_cnt[$];
  logic [3:0]  cap_grant[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_pend  = 1'b0;
    m_q.delete();
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
  endfunction

  function automatic logic [3:0] m_ready(input logic e);
    return (m_owner >= 0 && !m_pend && e) ? m_grant() : 4'b0;
  endfunction

  function automatic logic [31:0] m_data();
    logic [31:0] d = '0;
    foreach (m_q[i]) d[4*i +: 4] = m_q[i];
    return d;
  endfunction

  function automatic void m_update(input logic r, input logic e, input logic [3:0] v,
                                   input logic [15:0] s, input logic [3:0] l, input logic rd);
    if (r) begin
      m_reset();
    end else if (e) begin
      if (m_owner < 0) begin
        for (int d = 1; d <= NREQ; d++) begin
          int k = (m_last + d) % NREQ;
          if (m_owner < 0 && v[k]) m_owner = k;
        end
        m_q.delete();
      end else if (!m_pend) begin
        if (v[m_owner]) begin
          m_q.push_back(s[4*m_owner +: 4]);
          if (m_q.size() == PQ || l[m_owner]) m_pend = 1'b1;
        end
      end else if (rd) begin
        m_last  = m_owner;
        m_owner = -1;
        m_pend  = 1'b0;
        m_q.delete();
      end
    end
  endfunction

  task automatic step_pre(input logic r, input logic e, input logic [3:0] v,
                          input logic [15:0] s, input logic [3:0] l, input logic rd);
    cur_r = r; cur_e = e; cur_v = v; cur_s = s; cur_l = l; cur_rd = rd;
    rst = r;
    bus.i_en = e;
    bus.i_req_valid = v;
    bus.i_req_sym = s;
    bus.i_req_last = l;
    bus.i_ready = rd;
    #1;
    if (m_live) begin
      chk("model_grant", bus.o_grant, m_grant());
      chk("model_ready", bus.o_req_ready, m_ready(e));
      chk("model_valid", bus.o_valid, m_pend);
      chk("model_count", bus.o_sym_count, m_q.size());
      chk("model_data", bus.o_all_symbols_4b, m_data());
    end
    if (!r && e && rd && bus.o_valid === 1'b1) begin
      cap_data.push_back(bus.o_all_symbols_4b);
      cap_cnt.push_back(int'(bus.o_sym_count));
      cap_grant.push_back(bus.o_grant);
    end
  endtask

  task automatic step_post();
    @(posedge clk);
    m_update(cur_r, cur_e, cur_v, cur_s, cur_l, cur_rd);
    if (cur_r) m_live = 1'b1;
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] v,
                      input logic [15:0] s, input logic [3:0] l, input logic rd);
    step_pre(r, e, v, s, l, rd);
    step_post();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'b0, 16'h0, 4'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0, 16'h0, 4'b0, 1'b0);
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_cnt.delete();
    cap_grant.delete();
  endtask

  // Symbols are 1,2,3.. (mod 16) from one requester; downstream always ready.
  task automatic run_burst(input int req, input int n, input int maxcyc);
    int sent = 0;
    logic [3:0]  v, l;
    logic [15:0] s;
    clear_caps();
    for (int c = 0; c < maxcyc; c++) begin
      v = '0; s = '0; l = '0;
      if (sent < n) begin
        v[req] = 1'b1;
        s[4*req +: 4] = 4'(sent + 1);
        l[req] = (sent == n - 1);
      end
      step_pre(1'b0, 1'b1, v, s, l, 1'b1);
      if (sent < n && bus.o_req_ready[req] === 1'b1) sent++;
      step_post();
    end
    chk("burst_sent", sent, n);
  endtask

  typedef struct {
    logic        r, e;
    logic [3:0]  v;
    logic [15:0] s;
    logic [3:0]  l;
    logic        rd;
    logic [3:0]  g, rdy;
    logic        vld;
    logic [3:0]  cnt;
    logic [31:0] d;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] grants[$];
    logic [3:0] prev;

    m_reset();
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_req_valid = '0; bus.i_req_sym = '0;
    bus.i_req_last = '0; bus.i_ready = 1'b0;
    @(negedge clk);

    // Requester 1 sends A,B,C with last on C.
    tbl[0] = '{1'b0, 1'b1, 4'b0010, 16'h00A0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 4'b0010, 16'h00A0, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'd0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 4'b0010, 16'h00B0, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'd1, 32'h0000000A};
    tbl[3] = '{1'b0, 1'b1, 4'b0010, 16'h00C0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'd2, 32'h000000BA};
    tbl[4] = '{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 4'd3, 32'h00000CBA};
    tbl[5] = '{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'd3, 32'h00000CBA};
    tbl[6] = '{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0};

    step_pre(1'b1, 1'b0, 4'b0, 16'h0, 4'b0, 1'b0);
    step_post();
    step_pre(1'b1, 1'b1, 4'b1111, 16'hFFFF, 4'b1111, 1'b1);
    chk("reset_valid", bus.o_valid, 1'b0);
    chk("reset_grant", bus.o_grant, 4'b0);
    chk("reset_ready", bus.o_req_ready, 4'b0);
    chk("reset_count", bus.o_sym_count, 4'd0);
    chk("reset_data", bus.o_all_symbols_4b, 32'h0);
    step_post();

    for (int i = 0; i < 7; i++) begin
      step_pre(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].rd);
      chk($sformatf("tbl%0d_grant", i), bus.o_grant, tbl[i].g);
      chk($sformatf("tbl%0d_ready", i), bus.o_req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), bus.o_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_count", i), bus.o_sym_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_data", i), bus.o_all_symbols_4b, tbl[i].d);
      step_post();
    end

    // Requester 2 sends 1..8.
    run_burst(2, 8, 16);
    chk("r2_words", cap_data.size(), 1);
    if (cap_data.size() >= 1) begin
      chk("r2_data", cap_data[0], 32'h87654321);
      chk("r2_count", cap_cnt[0], 8);
      chk("r2_grant", cap_grant[0], 4'b0100);
    end

    // 12-symbol burst from requester 0 splits into two words.
    run_burst(0, 12, 24);
    chk("split_words", cap_data.size(), 2);
    if (cap_data.size() >= 2) begin
      chk("split_data0", cap_data[0], 32'h87654321);
      chk("split_count0", cap_cnt[0], 8);
      chk("split_data1", cap_data[1], 32'h0000CBA9);
      chk("split_count1", cap_cnt[1], 4);
      chk("split_grant1", cap_grant[1], 4'b0001);
    end

    // Requesters 0,1,3 persist with single-symbol bursts.
    do_reset();
    prev = 4'b0;
    for (int c = 0; c < 16; c++) begin
      step_pre(1'b0, 1'b1, 4'b1011, 16'h5321, 4'b1011, 1'b1);
      if (bus.o_grant !== 4'b0 && prev === 4'b0) grants.push_back(bus.o_grant);
      prev = bus.o_grant;
      step_post();
    end
    while (grants.size() < 4) grants.push_back(4'bx);
    chk("rr_first", grants[0], 4'b0001);
    chk("rr_second", grants[1], 4'b0010);
    chk("rr_third", grants[2], 4'b1000);
    chk("rr_fourth", grants[3], 4'b0001);

    // Output back-pressure then disabled handshake.
    do_reset();
    step(1'b0, 1'b1, 4'b1000, 16'h5000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 16'h5000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b1000, 16'h6000, 4'b1000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step_pre(1'b0, 1'b1, 4'b0, 16'h0, 4'b0, 1'b0);
      chk("hold_valid", bus.o_valid, 1'b1);
      chk("hold_data", bus.o_all_symbols_4b, 32'h00000065);
      chk("hold_count", bus.o_sym_count, 4'd2);
      step_post();
    end
    for (int c = 0; c < 2; c++) begin
      step_pre(1'b0, 1'b0, 4'b0, 16'h0, 4'b0, 1'b1);
      chk("dis_valid", bus.o_valid, 1'b1);
      chk("dis_data", bus.o_all_symbols_4b, 32'h00000065);
      chk("dis_grant", bus.o_grant, 4'b1000);
      step_post();
    end
    step_pre(1'b0, 1'b1, 4'b0, 16'h0, 4'b0, 1'b1);
    chk("hs_valid", bus.o_valid, 1'b1);
    step_post();
    step_pre(1'b0, 1'b1, 4'b0, 16'h0, 4'b0, 1'b0);
    chk("post_hs_valid", bus.o_valid, 1'b0);
    chk("post_hs_grant", bus.o_grant, 4'b0);
    step_post();

    // Reset mid-collect discards the partial word.
    do_reset();
    step(1'b0, 1'b1, 4'b0001, 16'h0001, 4'b0, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 4'b0001, 16'(c + 1), 4'b0, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 16'h0005, 4'b0, 1'b0);
    step_pre(1'b0, 1'b0, 4'b0, 16'h0, 4'b0, 1'b0);
    chk("midrst_grant", bus.o_grant, 4'b0);
    chk("midrst_valid", bus.o_valid, 1'b0);
    chk("midrst_count", bus.o_sym_count, 4'd0);
    chk("midrst_data", bus.o_all_symbols_4b, 32'h0);
    chk("midrst_ready", bus.o_req_ready, 4'b0);
    step_post();
    step(1'b0, 1'b1, 4'b0101, 16'h0907, 4'b0101, 1'b0);
    step_pre(1'b0, 1'b1, 4'b0101, 16'h0907, 4'b0101, 1'b0);
    chk("midrst_regrant", bus.o_grant, 4'b0001);
    step_post();
    step_pre(1'b0, 1'b1, 4'b0, 16'h0, 4'b0, 1'b0);
    chk("midrst_newcount", bus.o_sym_count, 4'd1);
    chk("midrst_newdata", bus.o_all_symbols_4b, 32'h00000007);
    step_post();
    step(1'b0, 1'b1, 4'b0, 16'h0, 4'b0, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] l;
      l = '0;
      for (int b = 0; b < NREQ; b++) l[b] = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, 4'($urandom),
           16'($urandom), l, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
